// File: rtl/mem_arbiter_if.sv
// CPU / GPU-loader request buses and the single-port memory bus behind the arbiter.
interface mem_arbiter_if;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        gpu_req, gpu_we, gpu_lock, gpu_gnt, gpu_rvalid;
  logic [15:0] gpu_addr, gpu_wdata, gpu_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  // arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  gpu_req, gpu_we, gpu_lock, gpu_addr, gpu_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output gpu_gnt, gpu_rvalid, gpu_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  // requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output gpu_req, gpu_we, gpu_lock, gpu_addr, gpu_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  gpu_gnt, gpu_rvalid, gpu_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: CPU priority with GPU anti-starvation,
// bounded GPU lock, one-cycle read return routed by an owner tag.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 8
) (
  input  logic clk,
  input  logic clr,
  mem_arbiter_if.slave bus
);
  typedef enum logic {ARB, LOCKED} state_t;

  localparam logic [3:0] STARVE_TOP = 4'(STARVE_LIMIT);
  localparam logic [7:0] LOCK_TOP   = 8'(LOCK_MAX);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic [7:0] lock_cnt, lock_nxt;
  logic       lock_block, block_nxt;
  logic       post_lock, post_nxt;   // first ARB cycle after a lock exit
  logic       cpu_tag, gpu_tag;      // owner of the read returning next cycle
  logic       cg, gg;                // raw grants before reset gating
  logic       cpu_gnt, gpu_gnt;

  // Grant decision and next-state for FSM and counters
  always_comb begin
    cg         = 1'b0;
    gg         = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    lock_nxt   = lock_cnt;
    block_nxt  = lock_block;
    post_nxt   = 1'b0;
    case (state)
      ARB: begin
        if (bus.cpu_req && bus.gpu_req) begin
          if (!post_lock && starve_cnt == STARVE_TOP) gg = 1'b1;
          else                                        cg = 1'b1;
        end else begin
          cg = bus.cpu_req;
          gg = bus.gpu_req;
        end
        if (gg && bus.gpu_lock && !lock_block) begin
          state_nxt = LOCKED;
          lock_nxt  = 8'd1;
        end
      end
      LOCKED: begin
        gg       = bus.gpu_req;
        lock_nxt = lock_cnt + 8'd1;
        if (!bus.gpu_lock) begin
          state_nxt = ARB;
          post_nxt  = 1'b1;
          lock_nxt  = 8'd0;
        end else if (lock_cnt == LOCK_TOP) begin
          // forced exit: GPU must drop gpu_lock before it may lock again
          state_nxt = ARB;
          post_nxt  = 1'b1;
          block_nxt = 1'b1;
          lock_nxt  = 8'd0;
        end
      end
      default: state_nxt = ARB;
    endcase
    // saturate so a post-lock CPU win can never push past the limit
    if (gg)
      starve_nxt = 4'd0;
    else if (cg && bus.gpu_req && starve_cnt < STARVE_TOP)
      starve_nxt = starve_cnt + 4'd1;
    if (!bus.gpu_lock) block_nxt = 1'b0;
  end

  // Grants are forced low while reset is held
  assign cpu_gnt     = cg & clr;
  assign gpu_gnt     = gg & clr;
  assign bus.cpu_gnt = cpu_gnt;
  assign bus.gpu_gnt = gpu_gnt;

  // Memory bus mux of the granted requester; idle bus is all zero
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'h0;
    bus.mem_wdata = 16'h0;
    if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (gpu_gnt) begin
      bus.mem_we    = bus.gpu_we;
      bus.mem_addr  = bus.gpu_addr;
      bus.mem_wdata = bus.gpu_wdata;
    end
  end

  // State, counters and read owner tag
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
      lock_cnt   <= 8'd0;
      lock_block <= 1'b0;
      post_lock  <= 1'b0;
      cpu_tag    <= 1'b0;
      gpu_tag    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      lock_cnt   <= lock_nxt;
      lock_block <= block_nxt;
      post_lock  <= post_nxt;
      cpu_tag    <= cpu_gnt & ~bus.cpu_we;
      gpu_tag    <= gpu_gnt & ~bus.gpu_we;
    end
  end

  assign bus.cpu_rvalid = cpu_tag;
  assign bus.gpu_rvalid = gpu_tag;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.gpu_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a rule-level reference model.
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int LM = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  // behavioural single-port memory, one-cycle read latency
  logic [15:0] tbmem [0:65535];
  always @(posedge clk) begin
    bus.mem_rdata <= tbmem[bus.mem_addr];
    if (bus.mem_we) tbmem[bus.mem_addr] <= bus.mem_wdata;
  end

  int n_chk = 0, n_fail = 0;

  // reference model state
  bit          m_locked, m_block, m_post, m_cpend, m_gpend;
  int          m_starve, m_lock_cnt;
  logic [15:0] m_data;

  // per-cycle observed / expected snapshot
  logic [52:0] obs_v, exp_v;
  logic        o_cg, o_gg, o_we, o_crv, o_grv;
  logic [15:0] o_addr, o_rd;

  task automatic model_reset();
    m_locked = 0; m_block = 0; m_post = 0; m_cpend = 0; m_gpend = 0;
    m_starve = 0; m_lock_cnt = 0; m_data = 16'h0;
  endtask

  // one clock cycle: drive, snapshot before the edge, advance model at the edge
  task automatic step(input bit cr, cw, input logic [15:0] ca, cd,
                      input bit gr, gw, gl, input logic [15:0] ga, gd);
    bit ecg, egg, ewe, nc, ng, post;
    logic [15:0] eaddr, edat, nd;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.gpu_req = gr; bus.gpu_we = gw; bus.gpu_lock = gl; bus.gpu_addr = ga; bus.gpu_wdata = gd;
    #3;
    if (m_locked)      begin ecg = 0; egg = gr; end
    else if (cr && gr) begin ecg = m_post || (m_starve != SL); egg = !ecg; end
    else               begin ecg = cr; egg = gr; end
    ewe   = ecg ? cw : (egg ? gw : 1'b0);
    eaddr = ecg ? ca : (egg ? ga : 16'h0);
    edat  = ecg ? cd : (egg ? gd : 16'h0);
    exp_v = {ecg, egg, ewe, eaddr, edat, m_cpend, m_gpend, (m_cpend || m_gpend) ? m_data : 16'h0};
    o_cg = bus.cpu_gnt; o_gg = bus.gpu_gnt; o_we = bus.mem_we; o_addr = bus.mem_addr;
    o_crv = bus.cpu_rvalid; o_grv = bus.gpu_rvalid;
    o_rd  = o_crv ? bus.cpu_rdata : (o_grv ? bus.gpu_rdata : 16'h0);
    obs_v = {o_cg, o_gg, o_we, o_addr, (ecg || egg) ? bus.mem_wdata : 16'h0, o_crv, o_grv, o_rd};
    nc = ecg && !cw;
    ng = egg && !gw;
    nd = tbmem[eaddr];
    @(posedge clk);
    m_cpend = nc; m_gpend = ng; m_data = nd;
    if (egg) m_starve = 0;
    else if (ecg && gr && m_starve < SL) m_starve++;
    post = 0;
    if (!m_locked) begin
      if (egg && gl && !m_block) begin m_locked = 1; m_lock_cnt = 1; end
    end else if (!gl) begin
      m_locked = 0; post = 1;
    end else if (m_lock_cnt == LM) begin
      m_locked = 0; post = 1; m_block = 1;
    end else m_lock_cnt++;
    if (!gl) m_block = 0;
    m_post = post;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    #1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h1111; bus.cpu_wdata = 16'h2222;
    bus.gpu_req = 1; bus.gpu_we = 1; bus.gpu_lock = 1; bus.gpu_addr = 16'h3333; bus.gpu_wdata = 16'h4444;
    #2;
    n_chk++;
    if ({bus.cpu_gnt, bus.gpu_gnt, bus.mem_we, bus.cpu_rvalid, bus.gpu_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.cpu_gnt, bus.gpu_gnt, bus.mem_we, bus.cpu_rvalid, bus.gpu_rvalid});
    end
    n_chk++;
    if (bus.mem_addr !== 16'h0) begin
      n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr);
    end
    @(posedge clk); #1;
    clr = 1;
    model_reset();
    // first contended access after release: CPU, starve count at zero
    step(1, 0, 16'h0020, 16'h0, 1, 0, 0, 16'h0030, 16'h0);
    n_chk++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_first_arb: got %h want %h", obs_v, exp_v); end
    idle();
    n_chk++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_first_ret: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_cpu_read();
    step(1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    n_chk++;
    if (o_cg !== 1'b1 || o_addr !== 16'h0010) begin
      n_fail++; $display("FAIL cpu_read_gnt: got gnt=%b addr=%h want gnt=1 addr=0010", o_cg, o_addr);
    end
    idle();
    n_chk++;
    if (o_crv !== 1'b1 || o_grv !== 1'b0 || o_rd !== tbmem[16'h0010]) begin
      n_fail++;
      $display("FAIL cpu_read_ret: got crv=%b grv=%b rd=%h want 1 0 %h", o_crv, o_grv, o_rd, tbmem[16'h0010]);
    end
  endtask

  task automatic test_starve();
    int gpu_seen;
    gpu_seen = 0;
    step(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0100, 16'h0);   // GPU-only clears starvation
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 16'(i), 16'h0, 1, 0, 0, 16'(16'h0200 + i), 16'h0);
      n_chk++;
      if (o_gg !== ((i % 5) == 4) || o_cg !== ((i % 5) != 4)) begin
        n_fail++; $display("FAIL starve_pattern[%0d]: got cg=%b gg=%b want gg=%b", i, o_cg, o_gg, (i % 5) == 4);
      end
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL starve_model[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
    idle();
  endtask

  task automatic test_lock_normal();
    logic [3:0] cg_seen;
    step(0, 0, 16'h0, 16'h0, 1, 0, 1, 16'hFFFF, 16'h0);          // GPU read, takes lock
    step(1, 0, 16'h0050, 16'h0, 1, 1, 1, 16'hFFFF, 16'h0001);    // locked: GPU write
    cg_seen[0] = o_cg;
    n_chk++;
    if (o_grv !== 1'b1 || o_gg !== 1'b1) begin
      n_fail++; $display("FAIL lock_read_ret: got grv=%b gg=%b want 1 1", o_grv, o_gg);
    end
    step(1, 0, 16'h0050, 16'h0, 0, 0, 0, 16'h0, 16'h0);          // lock drops, exit at edge
    cg_seen[1] = o_cg;
    step(1, 0, 16'h0050, 16'h0, 1, 0, 0, 16'h0060, 16'h0);       // first ARB cycle: CPU wins
    cg_seen[2] = o_cg;
    cg_seen[3] = o_gg;
    n_chk++;
    if (cg_seen !== 4'b0100) begin
      n_fail++; $display("FAIL lock_normal_gnts: got %b want 0100", cg_seen);
    end
    n_chk++;
    if (tbmem[16'hFFFF] !== 16'h0001) begin
      n_fail++; $display("FAIL lock_write_data: got %h want 0001", tbmem[16'hFFFF]);
    end
    idle();
  endtask

  task automatic test_lock_forced();
    logic [19:0] pat;
    pat = 20'b1011110111_1000000000;   // expected cpu_gnt per cycle, bit i = cycle i
    for (int i = 0; i < 20; i++) begin
      step(i != 0, 0, 16'(16'h0400 + i), 16'h0, 1, 0, 1, 16'(16'h0500 + i), 16'h0);
      n_chk++;
      if (o_cg !== pat[i]) begin
        n_fail++; $display("FAIL lock_forced_cg[%0d]: got %b want %b", i, o_cg, pat[i]);
      end
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL lock_forced_model[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
    idle();
  endtask

  task automatic test_reset_mid_lock();
    step(0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h0700, 16'h0);
    step(1, 0, 16'h0710, 16'h0, 1, 0, 1, 16'h0701, 16'h0);  // locked read, return pending
    #1 clr = 0;
    #1;
    n_chk++;
    if ({bus.cpu_gnt, bus.gpu_gnt, bus.mem_we, bus.cpu_rvalid, bus.gpu_rvalid} !== 5'b0 || bus.mem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_lock: got %b addr=%h want 00000 addr=0000",
               {bus.cpu_gnt, bus.gpu_gnt, bus.mem_we, bus.cpu_rvalid, bus.gpu_rvalid}, bus.mem_addr);
    end
    @(posedge clk); #1;
    clr = 1;
    model_reset();
    step(1, 0, 16'h0720, 16'h0, 1, 0, 1, 16'h0702, 16'h0);  // back in ARB: CPU wins
    n_chk++;
    if (o_cg !== 1'b1 || o_grv !== 1'b0 || obs_v !== exp_v) begin
      n_fail++; $display("FAIL reset_mid_lock_arb: got %h want %h", obs_v, exp_v);
    end
    idle();
    n_chk++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_mid_lock_ret: got %h want %h", obs_v, exp_v); end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 1, 16'h0040, 16'h1234, 0, 0, 0, 16'h0, 16'h0);
      else            step(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0040, 16'h0);
      n_chk++;
      if (o_we !== (i % 2 == 0) || o_grv !== (i % 2 == 0 && i > 0)) begin
        n_fail++; $display("FAIL alt[%0d]: got we=%b grv=%b", i, o_we, o_grv);
      end
      if (i % 2 == 0 && i > 0) begin
        n_chk++;
        if (o_rd !== 16'h1234) begin n_fail++; $display("FAIL alt_rdata[%0d]: got %h want 1234", i, o_rd); end
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 63)), 16'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
           16'($urandom_range(0, 63)), 16'($urandom));
      n_chk++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs_v, exp_v); end
    end
    idle();
    idle();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) tbmem[a] = 16'(a * 7 + 3);
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.gpu_req = 0; bus.gpu_we = 0; bus.gpu_lock = 0; bus.gpu_addr = 0; bus.gpu_wdata = 0;
    model_reset();
    @(posedge clk);
    test_reset();
    test_cpu_read();
    test_starve();
    test_lock_normal();
    test_lock_forced();
    test_reset_mid_lock();
    test_alternating();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
